peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/package_settings.sv | 16 +
 rtl/peak_event_buf.sv | 78 +++++++
 rtl/peak_detector.sv | 141 ++++++++++++++
 tb/tb_peak_detector.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// Shared settings for the peak detector: sample width, timing-field defaults
// and the detector FSM state encoding.
package package_settings;

   localparam int SIZE_FILTER_DATA   = 16;
   localparam int SIZE_TIME_DEFAULT  = 16;
   localparam int SIZE_WIDTH_DEFAULT = 8;
   localparam int SIZE_DROP          = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } peak_state_t;

endpackage

// File: rtl/peak_event_buf.sv
// One-deep event buffer with valid/ready handshake and saturating drop counter.
// Optional pile-up flag tracking is built only when PEAK_DETECTOR_PILEUP_EN is defined.
module peak_event_buf
   import package_settings::*;
#(
   parameter int SIZE_TIME  = SIZE_TIME_DEFAULT,
   parameter int SIZE_WIDTH = SIZE_WIDTH_DEFAULT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               new_valid,
   input  logic signed [SIZE_FILTER_DATA-1:0] new_amp,
   input  logic        [SIZE_TIME-1:0]        new_time,
   input  logic        [SIZE_WIDTH-1:0]       new_width,
   input  logic                               pileup_hit,
   input  logic                               event_ready,
   output logic                               event_valid,
   output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
   output logic        [SIZE_TIME-1:0]        peak_time,
   output logic        [SIZE_WIDTH-1:0]       peak_width,
   output logic                               pileup,
   output logic        [SIZE_DROP-1:0]        drop_count
);

   logic transfer;
   logic accept;

   // A new event is taken when the slot is empty or is emptied in the same cycle.
   assign transfer = event_valid & event_ready;
   assign accept   = new_valid & (~event_valid | transfer);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         event_valid <= 1'b0;
         peak_amp    <= '0;
         peak_time   <= '0;
         peak_width  <= '0;
         drop_count  <= '0;
      end else begin
         if (accept) begin
            event_valid <= 1'b1;
            peak_amp    <= new_amp;
            peak_time   <= new_time;
            peak_width  <= new_width;
         end else if (transfer) begin
            event_valid <= 1'b0;
         end
         if (new_valid && !accept && (drop_count != '1)) begin
            drop_count <= drop_count + SIZE_DROP'(1);
         end
      end
   end

`ifdef PEAK_DETECTOR_PILEUP_EN
   logic held_latest;

   // A dropped event makes the held one stale, so later pile-ups no longer apply to it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held_latest <= 1'b0;
         pileup      <= 1'b0;
      end else if (accept) begin
         held_latest <= 1'b1;
         pileup      <= 1'b0;
      end else if (new_valid) begin
         held_latest <= 1'b0;
      end else if (pileup_hit && event_valid && held_latest && !transfer) begin
         pileup <= 1'b1;
      end
   end
`else
   logic unused_pileup_hit;

   assign unused_pileup_hit = pileup_hit;
   assign pileup            = 1'b0;
`endif

endmodule

// File: rtl/peak_detector.sv
// Threshold-crossing peak detector: finds amplitude, time and width of each pulse.
// Define PEAK_DETECTOR_PILEUP_EN to flag crossings seen during the holdoff window.
module peak_detector
   import package_settings::*;
#(
   parameter int SIZE_TIME    = SIZE_TIME_DEFAULT,
   parameter int SIZE_WIDTH   = SIZE_WIDTH_DEFAULT,
   parameter int SIZE_HOLDOFF = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
   input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
   input  logic        [SIZE_HOLDOFF-1:0]     holdoff,
   input  logic                               event_ready,
   output logic                               event_valid,
   output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
   output logic        [SIZE_TIME-1:0]        peak_time,
   output logic        [SIZE_WIDTH-1:0]       peak_width,
   output logic                               pileup,
   output logic        [SIZE_DROP-1:0]        drop_count
);

   peak_state_t state;
   peak_state_t state_next;

   logic signed [SIZE_FILTER_DATA-1:0] sample;
   logic signed [SIZE_FILTER_DATA-1:0] max_amp;
   logic signed [SIZE_FILTER_DATA-1:0] max_amp_next;
   logic        [SIZE_TIME-1:0]        timestamp;
   logic        [SIZE_TIME-1:0]        max_time;
   logic        [SIZE_TIME-1:0]        max_time_next;
   logic        [SIZE_WIDTH-1:0]       width;
   logic        [SIZE_WIDTH-1:0]       width_next;
   logic        [SIZE_HOLDOFF-1:0]     hold_cnt;
   logic        [SIZE_HOLDOFF-1:0]     hold_cnt_next;
   logic                               above;
   logic                               emit;
   logic                               pileup_hit;

   // Input is registered once; the timestamp free-runs and wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample    <= '0;
         timestamp <= '0;
      end else begin
         sample    <= filter_data;
         timestamp <= timestamp + SIZE_TIME'(1);
      end
   end

   assign above = sample > threshold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         max_amp  <= '0;
         max_time <= '0;
         width    <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         max_amp  <= max_amp_next;
         max_time <= max_time_next;
         width    <= width_next;
         hold_cnt <= hold_cnt_next;
      end
   end

   // Strict greater-than on the maximum keeps the earliest sample of a plateau.
   always_comb begin
      state_next    = state;
      max_amp_next  = max_amp;
      max_time_next = max_time;
      width_next    = width;
      hold_cnt_next = hold_cnt;
      emit          = 1'b0;
      case (state)
         IDLE: begin
            if (above) begin
               state_next    = ARMED;
               max_amp_next  = sample;
               max_time_next = timestamp;
               width_next    = SIZE_WIDTH'(1);
            end
         end
         ARMED: begin
            if (above) begin
               if (width != '1) begin
                  width_next = width + SIZE_WIDTH'(1);
               end
               if (sample > max_amp) begin
                  max_amp_next  = sample;
                  max_time_next = timestamp;
               end
            end else begin
               emit          = 1'b1;
               state_next    = HOLDOFF;
               hold_cnt_next = holdoff;
            end
         end
         HOLDOFF: begin
            if (hold_cnt == '0) begin
               state_next = IDLE;
            end else begin
               hold_cnt_next = hold_cnt - SIZE_HOLDOFF'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef PEAK_DETECTOR_PILEUP_EN
   assign pileup_hit = (state == HOLDOFF) & above;
`else
   assign pileup_hit = 1'b0;
`endif

   peak_event_buf #(
      .SIZE_TIME  (SIZE_TIME),
      .SIZE_WIDTH (SIZE_WIDTH)
   ) u_event_buf (
      .clk         (clk),
      .reset       (reset),
      .new_valid   (emit),
      .new_amp     (max_amp),
      .new_time    (max_time),
      .new_width   (width),
      .pileup_hit  (pileup_hit),
      .event_ready (event_ready),
      .event_valid (event_valid),
      .peak_amp    (peak_amp),
      .peak_time   (peak_time),
      .peak_width  (peak_width),
      .pileup      (pileup),
      .drop_count  (drop_count)
   );

endmodule

// File: tb/tb_peak_detector.sv
// Directed self-checking bench for peak_detector; pile-up expectation follows
// whether PEAK_DETECTOR_PILEUP_EN is defined for the build.
module tb_peak_detector;
   import package_settings::*;

   logic clk = 1'b0;
   logic reset;
   logic signed [SIZE_FILTER_DATA-1:0] filter_data;
   logic signed [SIZE_FILTER_DATA-1:0] threshold;
   logic        [7:0]  holdoff;
   logic               event_ready;
   logic               event_valid;
   logic signed [SIZE_FILTER_DATA-1:0] peak_amp;
   logic        [15:0] peak_time;
   logic        [7:0]  peak_width;
   logic               pileup;
   logic        [7:0]  drop_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] ts_model;
   logic [15:0] drv_ts;

   always #5 clk = ~clk;

   // Timestamp the DUT attaches to a sample driven before the next rising edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) ts_model <= 16'd0;
      else        ts_model <= ts_model + 16'd1;
   end

   peak_detector dut (
      .clk         (clk),
      .reset       (reset),
      .filter_data (filter_data),
      .threshold   (threshold),
      .holdoff     (holdoff),
      .event_ready (event_ready),
      .event_valid (event_valid),
      .peak_amp    (peak_amp),
      .peak_time   (peak_time),
      .peak_width  (peak_width),
      .pileup      (pileup),
      .drop_count  (drop_count)
   );

   task automatic drive(input logic signed [15:0] v);
      @(negedge clk);
      filter_data = v;
      drv_ts      = ts_model + 16'd1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b0;
      filter_data = '0;
      event_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      drv_ts = 16'd0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({event_valid, peak_amp, peak_time, peak_width, pileup, drop_count} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got v=%0b a=%0d t=%0d w=%0d p=%0b d=%0d expected all 0",
                  event_valid, peak_amp, peak_time, peak_width, pileup, drop_count);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({event_valid, peak_amp, peak_time, peak_width, pileup, drop_count} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_held got v=%0b a=%0d t=%0d expected all 0",
                  event_valid, peak_amp, peak_time);
      end
   endtask

   task automatic test_single_pulse();
      logic [15:0] t300;
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd4;
      event_ready = 1'b1;
      drive(16'sd0); drive(16'sd50); drive(16'sd150);
      drive(16'sd300); t300 = drv_ts;
      drive(16'sd200); drive(16'sd90);
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL single_early got %0b expected 0", event_valid);
      end
      filter_data = 16'sd0;
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL single_valid got %0b expected 1", event_valid);
      end
      checks++;
      if (peak_amp !== 16'sd300) begin
         errors++; $display("[TB] FAIL single_amp got %0d expected 300", peak_amp);
      end
      checks++;
      if (peak_width !== 8'd3) begin
         errors++; $display("[TB] FAIL single_width got %0d expected 3", peak_width);
      end
      checks++;
      if (peak_time !== t300) begin
         errors++; $display("[TB] FAIL single_time got %0d expected %0d", peak_time, t300);
      end
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0 || drop_count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL single_after got v=%0b d=%0d expected v=0 d=0", event_valid, drop_count);
      end
   endtask

   task automatic test_plateau();
      logic [15:0] t_first;
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd0;
      event_ready = 1'b0;
      drive(16'sd0);
      drive(16'sd200); t_first = drv_ts;
      drive(16'sd200);
      drive(16'sd0);
      repeat (2) @(negedge clk);
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd200) begin
         errors++;
         $display("[TB] FAIL plateau_event got v=%0b a=%0d expected v=1 a=200", event_valid, peak_amp);
      end
      checks++;
      if (peak_time !== t_first) begin
         errors++; $display("[TB] FAIL plateau_time got %0d expected %0d", peak_time, t_first);
      end
      checks++;
      if (peak_width !== 8'd2) begin
         errors++; $display("[TB] FAIL plateau_width got %0d expected 2", peak_width);
      end
   endtask

   task automatic test_drop();
      logic [15:0] t_a;
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd0;
      event_ready = 1'b0;
      drive(16'sd150); t_a = drv_ts;
      repeat (4) drive(16'sd0);
      drive(16'sd250);
      repeat (4) drive(16'sd0);
      checks++;
      if (peak_amp !== 16'sd150 || peak_time !== t_a || drop_count !== 8'd1) begin
         errors++;
         $display("[TB] FAIL drop_hold1 got a=%0d t=%0d d=%0d expected a=150 t=%0d d=1",
                  peak_amp, peak_time, drop_count, t_a);
      end
      drive(16'sd350);
      repeat (4) drive(16'sd0);
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd150 || peak_width !== 8'd1 || peak_time !== t_a) begin
         errors++;
         $display("[TB] FAIL drop_hold2 got v=%0b a=%0d w=%0d t=%0d expected v=1 a=150 w=1 t=%0d",
                  event_valid, peak_amp, peak_width, peak_time, t_a);
      end
      checks++;
      if (drop_count !== 8'd2) begin
         errors++; $display("[TB] FAIL drop_count got %0d expected 2", drop_count);
      end
      @(negedge clk);
      event_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0 || drop_count !== 8'd2) begin
         errors++;
         $display("[TB] FAIL drop_release got v=%0b d=%0d expected v=0 d=2", event_valid, drop_count);
      end
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL drop_single_xfer got %0b expected 0", event_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd0;
      event_ready = 1'b0;
      drive(16'sd150);
      repeat (4) drive(16'sd0);
      drive(16'sd250);
      drive(16'sd0);
      @(negedge clk);
      event_ready = 1'b1;
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd150) begin
         errors++;
         $display("[TB] FAIL b2b_first got v=%0b a=%0d expected v=1 a=150", event_valid, peak_amp);
      end
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd250 || drop_count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL b2b_second got v=%0b a=%0d d=%0d expected v=1 a=250 d=0",
                  event_valid, peak_amp, drop_count);
      end
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_drain got %0b expected 0", event_valid);
      end
   endtask

   task automatic test_pileup();
      logic exp_pileup;
`ifdef PEAK_DETECTOR_PILEUP_EN
      exp_pileup = 1'b1;
`else
      exp_pileup = 1'b0;
`endif
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd10;
      event_ready = 1'b0;
      drive(16'sd0); drive(16'sd200);
      drive(16'sd0); drive(16'sd0); drive(16'sd0);
      checks++;
      if (event_valid !== 1'b1 || pileup !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pileup_clear got v=%0b p=%0b expected v=1 p=0", event_valid, pileup);
      end
      drive(16'sd0); drive(16'sd0); drive(16'sd300);
      drive(16'sd0); drive(16'sd0);
      checks++;
      if (pileup !== exp_pileup) begin
         errors++; $display("[TB] FAIL pileup_flag got %0b expected %0b", pileup, exp_pileup);
      end
      repeat (15) drive(16'sd0);
      checks++;
      if (peak_amp !== 16'sd200 || drop_count !== 8'd0 || pileup !== exp_pileup) begin
         errors++;
         $display("[TB] FAIL pileup_ignored got a=%0d d=%0d p=%0b expected a=200 d=0 p=%0b",
                  peak_amp, drop_count, pileup, exp_pileup);
      end
      event_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (event_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL pileup_drain got %0b expected 0", event_valid);
      end
   endtask

   task automatic test_reset_midpulse();
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd0;
      event_ready = 1'b0;
      drive(16'sd150);
      repeat (4) drive(16'sd0);
      drive(16'sd200); drive(16'sd500); drive(16'sd400);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({event_valid, peak_amp, peak_time, peak_width, pileup, drop_count} !== '0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs got v=%0b a=%0d t=%0d w=%0d expected all 0",
                  event_valid, peak_amp, peak_time, peak_width);
      end
      filter_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) drive(16'sd0);
      checks++;
      if (event_valid !== 1'b0 || drop_count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL midreset_no_event got v=%0b d=%0d expected v=0 d=0", event_valid, drop_count);
      end
      @(negedge clk);
      reset       = 1'b0;
      filter_data = 16'sd150;
      @(negedge clk);
      reset = 1'b1;
      drive(16'sd0);
      repeat (2) @(negedge clk);
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd150 || peak_width !== 8'd1) begin
         errors++;
         $display("[TB] FAIL first_sample got v=%0b a=%0d w=%0d expected v=1 a=150 w=1",
                  event_valid, peak_amp, peak_width);
      end
      checks++;
      if (peak_time !== 16'd1) begin
         errors++; $display("[TB] FAIL ts_restart got %0d expected 1", peak_time);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      threshold   = 16'sd100;
      holdoff     = 8'd0;
      event_ready = 1'b1;
      for (int i = 0; i < 70000 && drv_ts != 16'hFFFE; i++) begin
         drive(16'sd0);
      end
      drive(16'sd150);
      drive(16'sd300);
      drive(16'sd0);
      repeat (2) @(negedge clk);
      checks++;
      if (event_valid !== 1'b1 || peak_amp !== 16'sd300 || peak_width !== 8'd2) begin
         errors++;
         $display("[TB] FAIL wrap_event got v=%0b a=%0d w=%0d expected v=1 a=300 w=2",
                  event_valid, peak_amp, peak_width);
      end
      checks++;
      if (peak_time !== 16'h0000) begin
         errors++; $display("[TB] FAIL wrap_time got %0d expected 0", peak_time);
      end
   endtask

   initial begin
      reset       = 1'b0;
      filter_data = '0;
      threshold   = '0;
      holdoff     = '0;
      event_ready = 1'b0;
      drv_ts      = 16'd0;
      test_reset();
      test_single_pulse();
      test_plateau();
      test_drop();
      test_back_to_back();
      test_pileup();
      test_reset_midpulse();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
